// File: rtl/ecc_secded_link.sv
// SECDED link: extended-Hamming encode, optional fault injection, decode/correct,
// two-stage valid/ready pipeline and saturating error counters. Injection exists only with ECC_ERR_INJECT_EN.
module ecc_secded_link #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int P      = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int CODE_W = DATA_W + P + 1,
    localparam int IDX_W  = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        inj_mode,
    input  logic [IDX_W-1:0]  inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    input  logic              stat_clear,
    output logic [CNT_W-1:0]  cnt_corrected,
    output logic [CNT_W-1:0]  cnt_uncorrectable
);

    // Data bits occupy every non-power-of-two position from 3 upward, LSB first.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int i = 0; i < P; i++) begin
            for (int pos = 1; pos < CODE_W; pos++) begin
                if (((pos >> i) & 1) == 1 && pos != (1 << i)) begin
                    c[1 << i] = c[1 << i] ^ c[pos];
                end
            end
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic logic [P-1:0] syndrome(input logic [CODE_W-1:0] c);
        logic [P-1:0] s;
        s = '0;
        for (int i = 0; i < P; i++) begin
            for (int pos = 1; pos < CODE_W; pos++) begin
                if (((pos >> i) & 1) == 1) begin
                    s[i] = s[i] ^ c[pos];
                end
            end
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos];
                j++;
            end
        end
        return d;
    endfunction

    localparam logic [P:0]     CODE_W_SYN = (P + 1)'(CODE_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CODE_W-1:0] inj_mask;

`ifdef ECC_ERR_INJECT_EN
    logic [IDX_W:0] inj_pos2;

    always_comb begin
        inj_pos2 = {1'b0, inj_pos} + (IDX_W + 1)'(1);
        if (inj_pos2 >= (IDX_W + 1)'(CODE_W)) begin
            inj_pos2 = inj_pos2 - (IDX_W + 1)'(CODE_W);
        end
        inj_mask = '0;
        // An inj_pos beyond the codeword simply matches no bit.
        for (int k = 0; k < CODE_W; k++) begin
            if ((inj_mode == 2'b01 || inj_mode == 2'b10) && inj_pos == IDX_W'(k)) begin
                inj_mask[k] = 1'b1;
            end
            if (inj_mode == 2'b10 && inj_pos2 == (IDX_W + 1)'(k)) begin
                inj_mask[k] = 1'b1;
            end
        end
    end
`else
    logic unused_inj;
    assign unused_inj = ^{inj_mode, inj_pos};
    assign inj_mask   = '0;
`endif

    // Handshake: a word moves across a port on a rising edge where valid && ready;
    // valid never depends on ready, and in_ready is combinational from out_ready.
    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q,  s1_code_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic              s2_corr_q,  s2_corr_d;
    logic              s2_unc_q,   s2_unc_d;
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_unc_q,  cnt_unc_d;

    logic              s2_load;
    logic              s1_load;
    logic              out_fire;
    logic [P-1:0]      dec_syn;
    logic              dec_ovr;
    logic [CODE_W-1:0] dec_fixed;
    logic              dec_corr;
    logic              dec_unc;
    logic [DATA_W-1:0] dec_data;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        dec_syn   = syndrome(s1_code_q);
        dec_ovr   = ^s1_code_q;
        dec_fixed = s1_code_q;
        dec_corr  = 1'b0;
        dec_unc   = 1'b0;
        if (dec_ovr) begin
            // Odd overall parity with an in-range syndrome is one flipped bit (syndrome 0 = bit 0).
            if ({1'b0, dec_syn} < CODE_W_SYN) begin
                for (int k = 0; k < CODE_W; k++) begin
                    if (dec_syn == P'(k)) begin
                        dec_fixed[k] = ~dec_fixed[k];
                    end
                end
                dec_corr = 1'b1;
            end else begin
                dec_unc = 1'b1;
            end
        end else if (dec_syn != '0) begin
            dec_unc = 1'b1;
        end
        dec_data = extract(dec_fixed);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_corr_d  = s2_corr_q;
        s2_unc_d   = s2_unc_q;
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = encode(in_data) ^ inj_mask;
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            s2_corr_d  = s1_valid_q && dec_corr;
            s2_unc_d   = s1_valid_q && dec_unc;
            if (s1_valid_q) begin
                s2_data_d = dec_data;
            end
        end

        if (stat_clear) begin
            cnt_corr_d = '0;
            cnt_unc_d  = '0;
        end else if (out_fire) begin
            if (s2_corr_q && cnt_corr_q != CNT_MAX) begin
                cnt_corr_d = cnt_corr_q + 1'b1;
            end
            if (s2_unc_q && cnt_unc_q != CNT_MAX) begin
                cnt_unc_d = cnt_unc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_corr_q  <= 1'b0;
            s2_unc_q   <= 1'b0;
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_corr_q  <= s2_corr_d;
            s2_unc_q   <= s2_unc_d;
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
        end
    end

    assign in_ready          = !rst && s1_load;
    assign out_valid         = s2_valid_q;
    assign out_data          = s2_data_q;
    assign err_corrected     = s2_corr_q;
    assign err_uncorrectable = s2_unc_q;
    assign cnt_corrected     = cnt_corr_q;
    assign cnt_uncorrectable = cnt_unc_q;

endmodule

// File: tb/tb_ecc_secded_link.sv
// Bench for ecc_secded_link: vector table, stall/clear sequences, random traffic vs a queue model.
module tb_ecc_secded_link;
    localparam int DATA_W = 8;
    localparam int CODE_W = 13;
    localparam int IDX_W  = 4;
`ifdef ECC_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        inj_mode;
    logic [IDX_W-1:0]  inj_pos;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              err_c;
    logic              err_u;
    logic              stat_clear;
    logic [15:0]       cnt_c;
    logic [15:0]       cnt_u;
    logic              in_ready2;
    logic              out_valid2;
    logic [DATA_W-1:0] out_data2;
    logic              err_c2;
    logic              err_u2;
    logic [1:0]        cnt_c2;
    logic [1:0]        cnt_u2;

    ecc_secded_link #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_mode(inj_mode), .inj_pos(inj_pos), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err_corrected(err_c), .err_uncorrectable(err_u),
        .stat_clear(stat_clear), .cnt_corrected(cnt_c), .cnt_uncorrectable(cnt_u)
    );

    ecc_secded_link #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .inj_mode(inj_mode), .inj_pos(inj_pos), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .err_corrected(err_c2), .err_uncorrectable(err_u2),
        .stat_clear(stat_clear), .cnt_corrected(cnt_c2), .cnt_uncorrectable(cnt_u2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int popped = 0;
    int data_pos[DATA_W];
    logic [DATA_W+1:0] exp_q[$];
    int m_cc = 0, m_cu = 0, m_cc2 = 0, m_cu2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count the distinct flipped codeword bits; one flip is always repaired,
    // two flips are flagged and any flipped data bits show through.
    function automatic logic [DATA_W+1:0] model(input logic [DATA_W-1:0] d, input logic [1:0] mode,
                                                input logic [IDX_W-1:0] pos);
        bit [CODE_W-1:0] flips;
        logic [DATA_W-1:0] r;
        int n;
        flips = '0;
        if (INJ && (mode == 2'd1 || mode == 2'd2) && int'(pos) < CODE_W) flips[pos] = 1'b1;
        if (INJ && mode == 2'd2) flips[(int'(pos) + 1) % CODE_W] = 1'b1;
        n = $countones(flips);
        if (n == 0) return {d, 2'b00};
        if (n == 1) return {d, 2'b10};
        r = d;
        for (int j = 0; j < DATA_W; j++) if (flips[data_pos[j]]) r[j] = ~r[j];
        return {r, 2'b01};
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    always @(negedge clk) begin
        logic [DATA_W+1:0] e;
        if (rst) begin
            exp_q.delete();
            m_cc = 0; m_cu = 0; m_cc2 = 0; m_cu2 = 0;
        end else begin
            check("cnt_corrected", cnt_c, m_cc);
            check("cnt_uncorrectable", cnt_u, m_cu);
            check("cnt2_corrected", cnt_c2, m_cc2);
            check("cnt2_uncorrectable", cnt_u2, m_cu2);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("out_word", {out_data, err_c, err_u}, e);
                    check("out_word_dut2", {out_valid2, out_data2, err_c2, err_u2}, {1'b1, e});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                        if (!stat_clear) begin
                            if (e[1]) begin m_cc = sat_inc(m_cc, 65535); m_cc2 = sat_inc(m_cc2, 3); end
                            if (e[0]) begin m_cu = sat_inc(m_cu, 65535); m_cu2 = sat_inc(m_cu2, 3); end
                        end
                    end
                end
            end else begin
                check("idle_flags", {err_c, err_u}, 0);
            end
            if (stat_clear) begin
                m_cc = 0; m_cu = 0; m_cc2 = 0; m_cu2 = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, inj_mode, inj_pos));
        end
    end

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [1:0]        m;
        logic [IDX_W-1:0]  p;
        logic [DATA_W-1:0] ed;
        logic              ec;
        logic              eu;
    } vec_t;

    vec_t tbl[9];

    task automatic send_word(input logic [DATA_W-1:0] d, input logic [1:0] m, input logic [IDX_W-1:0] p);
        in_valid = 1'b1; in_data = d; inj_mode = m; inj_pos = p;
        @(negedge clk);
        check("send_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int j;
        int idx;
        int base;
        logic rdy;
        logic [DATA_W-1:0] w[3];
        j = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin data_pos[j] = pos; j++; end
        end

        tbl[0] = '{8'hAA, 2'd0, 4'd0,  8'hAA,             1'b0, 1'b0};
        tbl[1] = '{8'hCC, 2'd1, 4'd5,  8'hCC,             INJ,  1'b0};
        tbl[2] = '{8'hCC, 2'd1, 4'd0,  8'hCC,             INJ,  1'b0};
        tbl[3] = '{8'h55, 2'd2, 4'd3,  INJ ? 8'h54 : 8'h55, 1'b0, INJ};
        tbl[4] = '{8'h55, 2'd2, 4'd12, INJ ? 8'hD5 : 8'h55, 1'b0, INJ};
        tbl[5] = '{8'hFF, 2'd1, 4'd15, 8'hFF,             1'b0, 1'b0};
        tbl[6] = '{8'h00, 2'd1, 4'd8,  8'h00,             INJ,  1'b0};
        tbl[7] = '{8'h3C, 2'd3, 4'd2,  8'h3C,             1'b0, 1'b0};
        tbl[8] = '{8'hFF, 2'd1, 4'd1,  8'hFF,             INJ,  1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; inj_mode = '0; inj_pos = '0;
        out_ready = 1'b0; stat_clear = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {err_c, err_u}, 0);
        check("rst_counters", {cnt_c, cnt_u}, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_word(tbl[i].d, tbl[i].m, tbl[i].p);
            @(negedge clk);
            check("latency_n1", out_valid, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("latency_n2", out_valid, 1);
            check("tbl_word", {out_data, err_c, err_u}, {tbl[i].ed, tbl[i].ec, tbl[i].eu});
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("tbl_cnt_corrected", cnt_c, INJ ? 4 : 0);
        check("tbl_cnt2_saturated", cnt_c2, INJ ? 3 : 0);
        check("tbl_cnt_uncorrectable", cnt_u, INJ ? 2 : 0);
        @(posedge clk); #1;

        // Clear lands on the same edge as a corrected word leaving.
        send_word(8'hCC, 2'd1, 4'd5);
        @(posedge clk); #1;
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        @(negedge clk);
        check("clear_wins_cnt", cnt_c, 0);
        check("clear_wins_cnt2", cnt_c2, 0);
        @(posedge clk); #1;

        // Back-pressure: two words fill the pipe, third refused until release.
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03;
        base = popped;
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = w[idx < 3 ? idx : 2]; inj_mode = 2'd0;
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) idx++;
            #1;
        end
        check("stall_accepts", idx, 2);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_head", out_data, 8'h01);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (idx < 3 || exp_q.size() != 0); c++) begin
            in_valid = (idx < 3); in_data = w[idx < 3 ? idx : 2];
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) idx++;
            #1;
        end
        in_valid = 1'b0;
        check("stall_drain", exp_q.size(), 0);
        check("stall_popped", popped - base, 3);

        for (int c = 0; c < 400; c++) begin
            rst        = (c == 200);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = DATA_W'($urandom);
            inj_mode   = 2'($urandom_range(0, 3));
            inj_pos    = (inj_mode == 2'd2) ? IDX_W'($urandom_range(0, CODE_W - 1))
                                            : IDX_W'($urandom_range(0, 15));
            out_ready  = ($urandom_range(0, 3) != 0);
            stat_clear = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stat_clear = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check("final_drain", exp_q.size(), 0);
        @(negedge clk);
        check("final_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
